// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access and register writeback stage with a load/store FSM.
// Optional MEM_TIMEOUT_EN: abort a memory wait after TIMEOUT_CYCLES and set sticky memErr.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   aluResult, writeReg,    execute-side result and register write request
//   regAddress
//   address, storeData,     execute-side memory request
//   readEnable, writeEnable
//   dmemReq, dmemWe,        data memory request (held until dmemAck)
//   dmemAddr, dmemWdata
//   dmemAck, dmemRdata      memory completion, read data valid with ack
//   rfWe, rfAddr, rfData    register-file write port (one-cycle pulse)
//   stall                   upstream hold, high whenever not IDLE
//   instCount, memErr       retired instruction count, sticky timeout flag
module mem_wb_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] aluResult,
  input  logic        writeReg,
  input  logic [2:0]  regAddress,
  input  logic [15:0] address,
  input  logic [15:0] storeData,
  input  logic        readEnable,
  input  logic        writeEnable,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [15:0] dmemAddr,
  output logic [15:0] dmemWdata,
  input  logic        dmemAck,
  input  logic [15:0] dmemRdata,
  output logic        rfWe,
  output logic [2:0]  rfAddr,
  output logic [15:0] rfData,
  output logic        stall,
  output logic [15:0] instCount,
  output logic        memErr
);

`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Wait cycles are numbered from 0, so the abort fires on the last one.
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    STORE_WAIT,
    WB
  } state_t;

  state_t      state, state_n;

  logic        req_n, we_n;
  logic [15:0] addr_n, wdata_n;
  logic        rfwe_n;
  logic [2:0]  rfaddr_n;
  logic [15:0] rfdata_n;
  logic [15:0] cnt_n;
  logic        err_n;

  logic        ld_wr, ld_wr_n;
  logic [2:0]  ld_reg, ld_reg_n;
  logic [15:0] ld_data, ld_data_n;

  logic [15:0] wait_cnt, wait_cnt_n;
  logic        timeout;
  logic        retire;

  assign stall   = (state != IDLE);
  assign timeout = TO_EN && (wait_cnt == LIMIT);

  always_comb begin
    state_n    = state;
    req_n      = dmemReq;
    we_n       = dmemWe;
    addr_n     = dmemAddr;
    wdata_n    = dmemWdata;
    rfwe_n     = 1'b0;
    rfaddr_n   = rfAddr;
    rfdata_n   = rfData;
    err_n      = memErr;
    ld_wr_n    = ld_wr;
    ld_reg_n   = ld_reg;
    ld_data_n  = ld_data;
    wait_cnt_n = wait_cnt;
    retire     = 1'b0;

    unique case (state)
      IDLE: begin
        if (writeEnable) begin
          state_n    = STORE_WAIT;
          req_n      = 1'b1;
          we_n       = 1'b1;
          addr_n     = address;
          wdata_n    = storeData;
          wait_cnt_n = '0;
        end else if (readEnable) begin
          state_n    = LOAD_WAIT;
          req_n      = 1'b1;
          we_n       = 1'b0;
          addr_n     = address;
          ld_wr_n    = writeReg;
          ld_reg_n   = regAddress;
          wait_cnt_n = '0;
        end else begin
          // ALU ops and bubbles both retire here.
          retire = 1'b1;
          if (writeReg) begin
            rfwe_n   = 1'b1;
            rfaddr_n = regAddress;
            rfdata_n = aluResult;
          end
        end
      end

      LOAD_WAIT: begin
        if (dmemAck) begin
          state_n   = WB;
          req_n     = 1'b0;
          ld_data_n = dmemRdata;
        end else if (timeout) begin
          state_n = IDLE;
          req_n   = 1'b0;
          err_n   = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt + 16'd1;
        end
      end

      STORE_WAIT: begin
        if (dmemAck) begin
          state_n = IDLE;
          req_n   = 1'b0;
          we_n    = 1'b0;
          retire  = 1'b1;
        end else if (timeout) begin
          state_n = IDLE;
          req_n   = 1'b0;
          we_n    = 1'b0;
          err_n   = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt + 16'd1;
        end
      end

      WB: begin
        state_n = IDLE;
        retire  = 1'b1;
        if (ld_wr) begin
          rfwe_n   = 1'b1;
          rfaddr_n = ld_reg;
          rfdata_n = ld_data;
        end
      end
    endcase

    cnt_n = instCount + {15'd0, retire};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dmemReq   <= 1'b0;
      dmemWe    <= 1'b0;
      dmemAddr  <= '0;
      dmemWdata <= '0;
      rfWe      <= 1'b0;
      rfAddr    <= '0;
      rfData    <= '0;
      instCount <= '0;
      memErr    <= 1'b0;
      ld_wr     <= 1'b0;
      ld_reg    <= '0;
      ld_data   <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_n;
      dmemReq   <= req_n;
      dmemWe    <= we_n;
      dmemAddr  <= addr_n;
      dmemWdata <= wdata_n;
      rfWe      <= rfwe_n;
      rfAddr    <= rfaddr_n;
      rfData    <= rfdata_n;
      instCount <= cnt_n;
      memErr    <= err_n;
      ld_wr     <= ld_wr_n;
      ld_reg    <= ld_reg_n;
      ld_data   <= ld_data_n;
      wait_cnt  <= wait_cnt_n;
    end
  end

endmodule
